// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
//   An operation takes SIZE CALC steps followed by a one-cycle DONE state.
//   A zero divisor skips CALC and reports all-ones quotient, remainder = dividend.
//
// Ports
//   Clock       : rising-edge clock
//   Reset       : asynchronous active-low reset
//   iStart      : start request, sampled only while idle
//   iDividend   : unsigned dividend, captured on the accepting edge
//   iDivisor    : unsigned divisor, captured on the accepting edge
//   oQuotient   : quotient of the last completed operation
//   oRemainder  : remainder of the last completed operation
//   oBusy       : high whenever the FSM is not idle
//   oDone       : one-cycle pulse, high during the DONE state
//   oDivByZero  : last completed operation had a zero divisor
module seq_restoring_divider #(
    parameter int unsigned SIZE = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            iStart,
    input  logic [SIZE-1:0] iDividend,
    input  logic [SIZE-1:0] iDivisor,
    output logic [SIZE-1:0] oQuotient,
    output logic [SIZE-1:0] oRemainder,
    output logic            oBusy,
    output logic            oDone,
    output logic            oDivByZero
);

    localparam int unsigned REM_W = SIZE + 1;
    localparam int unsigned CNT_W = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    // Partial remainder never reaches the divisor, so SIZE bits hold it;
    // the SIZE+1-bit width only exists for the shifted trial value.
    logic [SIZE-1:0]   prem;
    // Dividend bits shift out of the top while quotient bits shift in below.
    logic [SIZE-1:0]   dvd_q;
    logic [SIZE-1:0]   dvs;

    logic [REM_W-1:0]  shifted;
    logic [REM_W-1:0]  diff;
    logic              qbit;
    logic [SIZE-1:0]   prem_next;
    logic [SIZE-1:0]   dq_next;

    // One restoring step: shift, trial-subtract, keep or restore.
    always_comb begin
        shifted   = {prem, dvd_q[SIZE-1]};
        diff      = shifted - {1'b0, dvs};
        // A borrow sets the top bit of the difference.
        qbit      = ~diff[REM_W-1];
        prem_next = qbit ? diff[SIZE-1:0] : shifted[SIZE-1:0];
        dq_next   = {dvd_q[SIZE-2:0], qbit};
    end

    // Control FSM with datapath and registered outputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            prem       <= '0;
            dvd_q      <= '0;
            dvs        <= '0;
            oQuotient  <= '0;
            oRemainder <= '0;
            oBusy      <= 1'b0;
            oDone      <= 1'b0;
            oDivByZero <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (iStart) begin
                        dvd_q <= iDividend;
                        dvs   <= iDivisor;
                        cnt   <= '0;
                        prem  <= '0;
                        oBusy <= 1'b1;
                        if (iDivisor == '0) begin
                            // Zero divisor completes immediately.
                            oQuotient  <= '1;
                            oRemainder <= iDividend;
                            oDivByZero <= 1'b1;
                            oDone      <= 1'b1;
                            state      <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    prem  <= prem_next;
                    dvd_q <= dq_next;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(SIZE - 1)) begin
                        oQuotient  <= dq_next;
                        oRemainder <= prem_next;
                        oDivByZero <= 1'b0;
                        oDone      <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    oBusy <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
